bhand_rev: RTL
==============

Name: bhand_rev

Overview:
- Reverse-path companion to the buffered handshake (bhand).
- bhand breaks the forward data/valid path. bhand_rev breaks the backward path: idata_rdy is driven from a flop and never depends combinationally on odata_rdy.
- Uses a 2-entry skid buffer (output register plus skid register).
- Sits between a producer and consumer stage on long ready-path routes. It is chained with bhand to make a fully registered pipeline stage in the filter datapath.

Parameters:
- DATA_WIDTH, 8, width of idata/odata.
- COUNT_WIDTH, 4, width of xfer_cnt. Used only when BHAND_REV_COUNT_EN is defined.

Ports:
- clk  input  1  sole clock; all logic on posedge.
- rst  input  1  reset; synchronous, active-low (rst==0 sampled at posedge resets the block).
- idata  input  DATA_WIDTH  upstream data.
- idata_vld  input  1  upstream valid.
- idata_rdy  output  1  registered ready to upstream.
- odata  output  DATA_WIDTH  registered downstream data.
- odata_vld  output  1  registered downstream valid.
- odata_rdy  input  1  downstream ready.
- xfer_cnt  output  COUNT_WIDTH  output-transfer count. Present only with BHAND_REV_COUNT_EN.

Behaviour:
- Transfer definitions:
  - Input transfer: posedge with idata_vld && idata_rdy.
  - Output transfer: posedge with odata_vld && odata_rdy.
- State machine, one state register:
  - EMPTY: odata_vld=0, idata_rdy=1.
  - BUSY: odata_vld=1, idata_rdy=1.
  - FULL: odata_vld=1, idata_rdy=0.
- Reset (rst==0 at posedge), taking priority over everything:
  - state=EMPTY, odata_vld=0, idata_rdy=0, odata=0, skid=0.
  - Any in-flight or buffered data is discarded.
  - idata_rdy rises on the first posedge where rst==1.
- EMPTY:
  - Input transfer: odata<=idata, go to BUSY.
  - Otherwise hold.
- BUSY:
  - In and out together: odata<=idata, stay BUSY (full throughput, 1 word/cycle).
  - In only: skid<=idata, go to FULL; odata held.
  - Out only: go to EMPTY.
  - Neither: hold; odata stable.
- FULL:
  - Out transfer: odata<=skid, go to BUSY.
  - Otherwise hold. idata_vld is ignored because idata_rdy=0.
- Output encoding: idata_rdy and odata_vld are flops loaded from next-state decode. No combinational path from any input to any output.
- Latency: 1 cycle from input transfer to odata_vld/odata, when the block was EMPTY or draining.
- Ordering: strict FIFO; no word dropped or duplicated.
- Stability: while odata_vld=1 and odata_rdy=0, odata and odata_vld do not change.
- Bubble-free: in steady state with both sides always ready, one transfer per cycle.
- Backpressure from odata_rdy reaches idata_rdy one cycle later. The skid entry absorbs the word accepted in that cycle.
- idata_vld may deassert without a transfer; no requirement on upstream hold behaviour.
- Reset mid-stream: the next cycle shows odata_vld=0 and idata_rdy=0, regardless of the prior state.

Optional Feature:
- Macro: BHAND_REV_COUNT_EN.
- Defined:
  - Adds xfer_cnt port and a COUNT_WIDTH counter.
  - Counter increments by 1 on each output transfer and wraps modulo 2^COUNT_WIDTH (e.g. 15 -> 0 for width 4).
  - Reset value 0.
  - Output is registered.
- Undefined:
  - Port and counter are absent.
  - COUNT_WIDTH has no effect.
  - Datapath behaviour is identical.

Test Plan:
- Reset then pass-through:
  - Stimulus: rst=0 for 2 cycles, then rst=1; odata_rdy=1; idata=0x11,0x22,0x33 on consecutive cycles with vld=1.
  - Response: idata_rdy=0 during reset and 1 from the first cycle after release; odata shows 0x11,0x22,0x33 on consecutive cycles, each 1 cycle after its input; no bubbles.
- Skid fill:
  - Stimulus: odata_rdy=0, send 0xA1,0xA2,0xA3.
  - Response: 0xA1 on odata; 0xA2 accepted into skid; idata_rdy=0 from the next cycle; 0xA3 held by the producer.
  - Then raise odata_rdy: outputs are 0xA1,0xA2,0xA3 in order, and idata_rdy returns to 1 one cycle after the first output transfer.
- Random throttle:
  - Stimulus: 1000 random bytes; idata_vld and odata_rdy each random at 50%.
  - Response: output sequence equals input sequence; odata is stable while stalled; idata_rdy==0 only in FULL.
- Reset mid-operation:
  - Stimulus: block in FULL holding 0x5A,0x5B; assert rst=0 for 1 cycle.
  - Response: odata_vld=0, idata_rdy=0, odata=0 the next cycle; neither 0x5A nor 0x5B ever appears after release.
- Counter wrap (BHAND_REV_COUNT_EN, COUNT_WIDTH=4):
  - Stimulus: 17 output transfers.
  - Response: xfer_cnt reads 15 after 15 transfers, 0 after 16, and 1 after 17.
  - Without the macro, the module elaborates with no xfer_cnt port.

Source files
------------

// File: rtl/bhand_rev.sv
// bhand_rev -- reverse-path buffered handshake (registered-ready skid buffer).
//
// Breaks the backward ready path between a producer and a consumer. idata_rdy
// comes straight from a flop and never depends combinationally on odata_rdy.
// A 2-entry skid buffer (output register plus skid register) absorbs the word
// that is accepted in the cycle when downstream backpressure first appears.
//
// Parameters:
//   DATA_WIDTH   width of idata/odata
//   COUNT_WIDTH  width of xfer_cnt (only with BHAND_REV_COUNT_EN)
//
// Ports:
//   clk        sole clock, posedge
//   rst        synchronous active-low reset
//   idata      upstream data
//   idata_vld  upstream valid
//   idata_rdy  registered ready to upstream
//   odata      registered downstream data
//   odata_vld  registered downstream valid
//   odata_rdy  downstream ready
//   xfer_cnt   output-transfer count, wraps (only with BHAND_REV_COUNT_EN)
//
// Optional feature macro: BHAND_REV_COUNT_EN adds the xfer_cnt port/counter.

module bhand_rev #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned COUNT_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  idata,
    input  logic                   idata_vld,
    output logic                   idata_rdy,
    output logic [DATA_WIDTH-1:0]  odata,
    output logic                   odata_vld,
    input  logic                   odata_rdy
`ifdef BHAND_REV_COUNT_EN
    ,
    output logic [COUNT_WIDTH-1:0] xfer_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] odata_q, odata_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic                  odata_vld_q, odata_vld_d;
    logic                  idata_rdy_q, idata_rdy_d;
    logic                  in_xfer, out_xfer;

    assign in_xfer  = idata_vld && idata_rdy_q;
    assign out_xfer = odata_vld_q && odata_rdy;

    always_comb begin
        state_d = state_q;
        odata_d = odata_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    odata_d = idata;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (in_xfer && out_xfer) begin
                    odata_d = idata;
                end else if (in_xfer) begin
                    skid_d  = idata;
                    state_d = FULL;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // idata_rdy_q is 0 here, so no input transfer can occur.
                if (out_xfer) begin
                    odata_d = skid_q;
                    state_d = BUSY;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Handshake outputs are registered copies of the next-state decode.
        odata_vld_d = (state_d != EMPTY);
        idata_rdy_d = (state_d != FULL);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= EMPTY;
            odata_q     <= '0;
            skid_q      <= '0;
            odata_vld_q <= 1'b0;
            idata_rdy_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            odata_q     <= odata_d;
            skid_q      <= skid_d;
            odata_vld_q <= odata_vld_d;
            idata_rdy_q <= idata_rdy_d;
        end
    end

    assign idata_rdy = idata_rdy_q;
    assign odata     = odata_q;
    assign odata_vld = odata_vld_q;

`ifdef BHAND_REV_COUNT_EN
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (out_xfer) begin
            cnt_d = cnt_q + COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign xfer_cnt = cnt_q;
`else
    logic [COUNT_WIDTH-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

endmodule
